dtw_ref_mem_banked: RTL and testbench
=====================================

# dtw_ref_mem_banked

Multi-bank reference store for the DTW cores, replacing the single raw dual-port reference BRAM. It holds `BANKS` independent reference sequences, each in its own BRAM bank. Each bank is filled through an auto-incrementing load stream that tracks the stored length per bank. A read engine streams a bounded window from any bank with valid/ready backpressure, so DTW cores consume reference samples without driving raw addresses.

## Interface
Parameters:
- `WIDTH`, 16: sample width in bits.
- `PTR_WID`, 18: address width per bank.
- `DEPTH`, 2**PTR_WID: samples per bank.
- `BANKS`, 2: number of banks; `BANK_WID` = max(1, clog2(BANKS)).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `ld_start` in 1: pulse; latch `ld_bank`, clear that bank's length, zero the load pointer.
- `ld_bank` in BANK_WID: bank to load; sampled on `ld_start`.
- `ld_valid` in 1, `ld_data` in WIDTH: load beat.
- `ld_ready` out 1: load beat accepted when `ld_valid & ld_ready`.
- `ld_count` out PTR_WID+1: samples stored in the current load bank.
- `rd_start` in 1: pulse; request a read window.
- `rd_bank` in BANK_WID, `rd_addr` in PTR_WID, `rd_count` in PTR_WID+1: window spec; sampled on `rd_start`.
- `rd_valid` out 1, `rd_data` out WIDTH, `rd_last` out 1: output stream.
- `rd_ready` in 1: consumer ready.
- `rd_busy` out 1: read engine not IDLE.
- `rd_done` out 1: one-cycle pulse when the window completes.
- `rd_err` out 1: one-cycle pulse when a window is rejected.

## Operation
- Storage: one simple-dual-port block RAM per bank (write port = load, read port = stream). Registered read, read-first. Contents are not cleared by reset.
- Per-bank length register `len[b]`, PTR_WID+1 bits, range 0..DEPTH.
- Load path:
  - `ld_start` latches the bank, sets `len[bank]=0` and the pointer to 0.
  - Each accepted beat writes MEM[bank][ptr], increments ptr, and sets `len[bank]=ptr+1`.
  - `ld_ready` = loader armed, ptr<DEPTH, and not (`rd_busy` and read bank == load bank).
  - Loader is disarmed after reset until the first `ld_start`.
  - `ld_start` while loading restarts the load; `ld_valid` in the same cycle is ignored.
- Read engine FSM:
  - IDLE: on `rd_start`, compute `avail = len[rd_bank] - rd_addr`.
    - If `rd_addr >= len[rd_bank]` and `rd_count != 0`: pulse `rd_err`, stay IDLE.
    - If `rd_count == 0`: pulse `rd_done`, stay IDLE.
    - Otherwise: `remaining = min(rd_count, avail)` (silent truncation), go to STREAM.
  - STREAM: issue one read address per cycle while the skid buffer has room; decrement issue counter. When all addresses are issued, go to DRAIN.
  - DRAIN: wait until the final beat is accepted; pulse `rd_done` in that cycle's successor; return to IDLE.
- `rd_start` is ignored while `rd_busy`.
- Output buffering: 2-entry skid FIFO after the BRAM register, so no beat is lost when `rd_ready` drops.
- `rd_last` is high on the final beat of the window only.
- Bank index >= BANKS on `ld_start` or `rd_start`: the request is ignored (`rd_err` pulses for reads).

## Timing
- Reset values: `ld_ready`=0, `ld_count`=0, `rd_valid`=0, `rd_data`=0, `rd_last`=0, `rd_busy`=0, `rd_done`=0, `rd_err`=0, all `len`=0, FSM=IDLE.
- Load: a beat accepted at edge N is readable by a read address issued at edge N+1 or later.
- Read latency: `rd_start` at edge N puts the first `rd_valid` high after edge N+2.
- Throughput: 1 beat/cycle while `rd_ready`=1.
- Backpressure: once `rd_valid` is high, `rd_data` and `rd_last` hold stable until accepted.
- `rd_busy` rises the cycle after an accepted `rd_start` and falls with the `rd_done` pulse.
- `rd_err` is asserted the cycle after `rd_start`.
- Reset mid-operation: all state returns to reset values immediately; in-flight beats are discarded.

## Test plan
- Load bank 0 with 0..9 (10 beats), read `rd_addr`=0, `rd_count`=10, `rd_ready`=1 -> data 0..9 on consecutive cycles, first valid 2 cycles after start, `rd_last` on 9, `rd_done` once.
- Bank 0 holds 10, bank 1 holds 100..104; read bank 1 `addr`=3 `count`=8 -> beats 103,104 only (truncated), `rd_last` on 104.
- Read bank 0 `addr`=10 `count`=1 -> `rd_err` pulse, no `rd_valid`, `rd_busy` stays 0; `count`=0 at any addr -> `rd_done` pulse, no beats.
- Stream 10 beats with `rd_ready` toggling randomly -> all 10 received in order, none duplicated, data stable while stalled.
- Load bank 0 while streaming bank 0 -> `ld_ready`=0 until `rd_done`; loading bank 1 concurrently proceeds and the bank-0 stream is unaffected.
- Fill a bank with DEPTH beats (small-DEPTH build) -> `ld_ready` drops, `ld_count`=DEPTH. Assert `rst` mid-stream -> outputs at reset values next cycle, `len`=0, further reads give `rd_err`.

Source files
------------

// File: rtl/dtw_ref_mem_banked.sv
// dtw_ref_mem_banked: per-bank reference sample store for the DTW cores.
// Auto-increment bank loader plus a windowed streaming reader with backpressure.
module dtw_ref_mem_banked #(
  parameter int WIDTH    = 16,
  parameter int PTR_WID  = 18,
  parameter int DEPTH    = 2 ** PTR_WID,
  parameter int BANKS    = 2,
  parameter int BANK_WID = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_start,
  input  logic [BANK_WID-1:0] ld_bank,
  input  logic                ld_valid,
  input  logic [WIDTH-1:0]    ld_data,
  output logic                ld_ready,
  output logic [PTR_WID:0]    ld_count,
  input  logic                rd_start,
  input  logic [BANK_WID-1:0] rd_bank,
  input  logic [PTR_WID-1:0]  rd_addr,
  input  logic [PTR_WID:0]    rd_count,
  output logic                rd_valid,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_last,
  input  logic                rd_ready,
  output logic                rd_busy,
  output logic                rd_done,
  output logic                rd_err
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  localparam logic [BANK_WID:0] NBANK = (BANK_WID + 1)'(BANKS);
  localparam logic [PTR_WID:0] DEPTH_L = (PTR_WID + 1)'(DEPTH);
  localparam logic [PTR_WID:0] ONE = (PTR_WID + 1)'(1);

  state_t state;
  state_t state_nx;

  logic [PTR_WID:0] len [BANKS];

  logic                ld_armed;
  logic [BANK_WID-1:0] ld_bank_q;
  logic [PTR_WID:0]    ld_ptr;
  logic                ld_bank_ok;
  logic                ld_acc;

  logic [BANK_WID-1:0] rd_bank_q;
  logic [PTR_WID-1:0]  raddr;
  logic [PTR_WID:0]    issue_cnt;
  logic                rd_bank_ok;
  logic [PTR_WID:0]    rd_len;
  logic [PTR_WID:0]    avail;
  logic [PTR_WID:0]    remaining;

  logic issue;
  logic start_ok;
  logic done_nx;
  logic err_nx;

  logic                           pipe_v;
  logic                           pipe_last;
  logic [BANKS-1:0][WIDTH-1:0]    q_all;
  logic [WIDTH-1:0]               q_sel;

  logic [WIDTH-1:0] fifo_data [2];
  logic             fifo_last [2];
  logic [1:0]       fifo_cnt;
  logic             wptr;
  logic             rptr;
  logic             pop;
  logic [2:0]       occ;
  logic             room;

  // Loader
  assign ld_bank_ok = ({1'b0, ld_bank} < NBANK);
  assign ld_ready = ld_armed && (ld_ptr < DEPTH_L)
                 && !(rd_busy && (rd_bank_q == ld_bank_q));
  assign ld_acc = ld_valid && ld_ready && !ld_start;
  assign ld_count = len[ld_bank_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_armed  <= 1'b0;
      ld_bank_q <= '0;
      ld_ptr    <= '0;
      for (int b = 0; b < BANKS; b++) len[b] <= '0;
    end else if (ld_start) begin
      if (ld_bank_ok) begin
        ld_armed      <= 1'b1;
        ld_bank_q     <= ld_bank;
        ld_ptr        <= '0;
        len[ld_bank]  <= '0;
      end
    end else if (ld_acc) begin
      ld_ptr           <= ld_ptr + 1'b1;
      len[ld_bank_q]   <= ld_ptr + 1'b1;
    end
  end

  // One simple-dual-port RAM per bank; read-first, registered output
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    localparam logic [BANK_WID-1:0] BID = BANK_WID'(b);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] q;
    always_ff @(posedge clk) begin
      if (ld_acc && (ld_bank_q == BID))
        mem[ld_ptr[PTR_WID-1:0]] <= ld_data;
      if (issue && (rd_bank_q == BID))
        q <= mem[raddr];
    end
    assign q_all[b] = q;
  end

  assign q_sel = q_all[rd_bank_q];

  // Window request decode
  assign rd_bank_ok = ({1'b0, rd_bank} < NBANK);
  assign rd_len = rd_bank_ok ? len[rd_bank] : '0;
  assign avail = rd_len - {1'b0, rd_addr};
  assign remaining = (rd_count < avail) ? rd_count : avail;

  // Issue only if the beat in the BRAM register plus this one fit the FIFO
  assign pop = rd_valid && rd_ready;
  assign occ = {1'b0, fifo_cnt} + {2'b0, pipe_v} - {2'b0, pop};
  assign room = (occ <= 3'd1);

  assign rd_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    start_ok = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rd_start) begin
          if (!rd_bank_ok) begin
            err_nx = 1'b1;
          end else if (rd_count == '0) begin
            done_nx = 1'b1;
          end else if ({1'b0, rd_addr} >= rd_len) begin
            err_nx = 1'b1;
          end else begin
            start_ok = 1'b1;
            state_nx = STREAM;
          end
        end
      end
      STREAM: begin
        if (room) begin
          issue = 1'b1;
          if (issue_cnt == ONE) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && rd_last) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank_q <= '0;
      raddr     <= '0;
      issue_cnt <= '0;
      pipe_v    <= 1'b0;
      pipe_last <= 1'b0;
      rd_done   <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      rd_done <= done_nx;
      rd_err  <= err_nx;
      pipe_v  <= issue;
      if (start_ok) begin
        rd_bank_q <= rd_bank;
        raddr     <= rd_addr;
        issue_cnt <= remaining;
      end else if (issue) begin
        raddr     <= raddr + 1'b1;
        issue_cnt <= issue_cnt - 1'b1;
      end
      if (issue) pipe_last <= (issue_cnt == ONE);
    end
  end

  // Two-entry skid FIFO behind the BRAM register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_cnt <= '0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (pipe_v) begin
        fifo_data[wptr] <= q_sel;
        fifo_last[wptr] <= pipe_last;
        wptr            <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      fifo_cnt <= fifo_cnt + {1'b0, pipe_v} - {1'b0, pop};
    end
  end

  assign rd_valid = (fifo_cnt != 2'd0);
  assign rd_data  = fifo_data[rptr];
  assign rd_last  = rd_valid && fifo_last[rptr];

endmodule

// File: tb/tb_dtw_ref_mem_banked.sv
// tb_dtw_ref_mem_banked: randomized bench for the banked reference store.
// Expected windows come from a simple array model of per-bank contents/lengths.
module tb_dtw_ref_mem_banked;
  localparam int W  = 16;
  localparam int PW = 4;
  localparam int D  = 16;
  localparam int NB = 2;
  localparam int BW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_start = 1'b0;
  logic [BW-1:0] ld_bank = '0;
  logic          ld_valid = 1'b0;
  logic [W-1:0]  ld_data = '0;
  logic          ld_ready;
  logic [PW:0]   ld_count;
  logic          rd_start = 1'b0;
  logic [BW-1:0] rd_bank = '0;
  logic [PW-1:0] rd_addr = '0;
  logic [PW:0]   rd_count = '0;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          rd_last;
  logic          rd_ready = 1'b0;
  logic          rd_busy;
  logic          rd_done;
  logic          rd_err;

  dtw_ref_mem_banked #(
    .WIDTH(W), .PTR_WID(PW), .DEPTH(D), .BANKS(NB), .BANK_WID(BW)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_start(ld_start), .ld_bank(ld_bank),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_count(ld_count),
    .rd_start(rd_start), .rd_bank(rd_bank),
    .rd_addr(rd_addr), .rd_count(rd_count),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .rd_ready(rd_ready), .rd_busy(rd_busy),
    .rd_done(rd_done), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] ref_mem [NB][D];
  int           ref_len [NB];

  logic [W-1:0] exp_q [$];
  int           exp_err;
  int           exp_done;

  logic [W-1:0] got_data [$];
  logic         got_last [$];
  int first_cyc, last_cyc, n_done, n_err, n_unstable, timed_out, busy_seen;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_window(input int b, input int a, input int c);
    int n;
    exp_q.delete();
    exp_err = 0;
    if (b >= NB) exp_err = 1;
    else if (c == 0) exp_err = 0;
    else if (a >= ref_len[b]) exp_err = 1;
    else begin
      n = (c < ref_len[b] - a) ? c : ref_len[b] - a;
      for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[b][a + i]);
    end
    exp_done = exp_err ? 0 : 1;
  endtask

  task automatic load(input int b, input int n, input int base, input bit rnd);
    logic ok;
    logic [W-1:0] v;
    ld_start = 1'b1;
    ld_bank = b[BW-1:0];
    step();
    ld_start = 1'b0;
    ref_len[b] = 0;
    for (int i = 0; i < n; i++) begin
      v = rnd ? W'($urandom) : W'(base + i);
      ld_valid = 1'b1;
      ld_data = v;
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
        @(negedge clk);
        if (ld_ready === 1'b1) ok = 1'b1;
        else step();
      end
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL load_timeout bank %0d beat %0d: ld_ready stayed low, want high", b, i);
      end else begin
        ref_mem[b][i] = v;
        ref_len[b] = i + 1;
      end
      step();
    end
    ld_valid = 1'b0;
  endtask

  task automatic load_probe(input int b, input int n, input int base,
                            output int acc_busy, output int acc);
    acc_busy = 0;
    acc = 0;
    step();
    ld_start = 1'b1;
    ld_bank = b[BW-1:0];
    step();
    ld_start = 1'b0;
    ref_len[b] = 0;
    ld_valid = 1'b1;
    ld_data = W'(base);
    for (int cyc = 0; cyc < 100 && acc < n; cyc++) begin
      @(negedge clk);
      if (ld_ready === 1'b1) begin
        if (rd_busy === 1'b1) acc_busy++;
        ref_mem[b][acc] = W'(base + acc);
        acc++;
        ref_len[b] = acc;
      end
      step();
      ld_data = W'(base + acc);
    end
    ld_valid = 1'b0;
  endtask

  task automatic collect(input int b, input int a, input int c, input int pct);
    logic held;
    logic [W-1:0] hd;
    logic hl;
    int tail;
    got_data.delete();
    got_last.delete();
    first_cyc = -1; last_cyc = -1;
    n_done = 0; n_err = 0; n_unstable = 0;
    timed_out = 1; busy_seen = 0;
    held = 1'b0; hd = '0; hl = 1'b0; tail = -1;
    rd_start = 1'b1;
    rd_bank = b[BW-1:0];
    rd_addr = a[PW-1:0];
    rd_count = c[PW:0];
    rd_ready = ($urandom_range(99) < pct);
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (held && (rd_valid !== 1'b1 || rd_data !== hd || rd_last !== hl))
        n_unstable++;
      if (rd_valid === 1'b1 && first_cyc < 0) first_cyc = cyc;
      if (rd_busy === 1'b1) busy_seen = 1;
      if (rd_done === 1'b1) n_done++;
      if (rd_err === 1'b1) n_err++;
      if (rd_valid === 1'b1 && rd_ready) begin
        got_data.push_back(rd_data);
        got_last.push_back(rd_last);
        last_cyc = cyc;
        held = 1'b0;
      end else if (rd_valid === 1'b1) begin
        held = 1'b1; hd = rd_data; hl = rd_last;
      end else begin
        held = 1'b0;
      end
      if ((rd_done === 1'b1 || rd_err === 1'b1) && tail < 0) tail = cyc + 4;
      if (cyc == tail) begin
        timed_out = 0;
        break;
      end
      step();
      rd_start = 1'b0;
      rd_ready = ($urandom_range(99) < pct);
    end
    step();
    rd_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_cmp++;
    if ({ld_ready, ld_count, rd_valid, rd_data, rd_last, rd_busy, rd_done, rd_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got rdy=%b cnt=%0d v=%b d=%h l=%b busy=%b done=%b err=%b want all 0",
               ld_ready, ld_count, rd_valid, rd_data, rd_last, rd_busy, rd_done, rd_err);
    end
    step();
    rst = 1'b0;
    for (int b = 0; b < NB; b++) ref_len[b] = 0;
    step();
  endtask

  task automatic test_basic_read();
    load(0, 10, 0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (ld_count !== 5'd10) begin
      n_bad++;
      $display("FAIL basic_ld_count got %0d want 10", ld_count);
    end
    step();
    model_window(0, 0, 10);
    collect(0, 0, 10, 100);
    n_cmp++;
    if (timed_out != 0 || got_data.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL basic_beats got %0d beats (timeout=%0d) want %0d", got_data.size(), timed_out, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
          n_bad++;
          $display("FAIL basic_beat%0d got %h/last=%b want %h/last=%b", i, got_data[i], got_last[i],
                   exp_q[i], (i == exp_q.size() - 1));
        end
      end
    end
    n_cmp++;
    if (first_cyc != 3) begin
      n_bad++;
      $display("FAIL basic_latency got first valid at cycle %0d want 3", first_cyc);
    end
    n_cmp++;
    if (last_cyc - first_cyc != 9) begin
      n_bad++;
      $display("FAIL basic_throughput got span %0d want 9", last_cyc - first_cyc);
    end
    n_cmp++;
    if (n_done != 1 || n_err != 0) begin
      n_bad++;
      $display("FAIL basic_done got done=%0d err=%0d want 1/0", n_done, n_err);
    end
  endtask

  task automatic test_truncate();
    load(1, 5, 100, 1'b0);
    model_window(1, 3, 8);
    collect(1, 3, 8, 100);
    n_cmp++;
    if (got_data.size() != 2 || exp_q.size() != 2) begin
      n_bad++;
      $display("FAIL trunc_size got %0d want 2 (model %0d)", got_data.size(), exp_q.size());
    end else begin
      n_cmp++;
      if (got_data[0] !== exp_q[0] || got_data[1] !== exp_q[1] || got_data[1] !== 16'd104) begin
        n_bad++;
        $display("FAIL trunc_data got %0d,%0d want 103,104", got_data[0], got_data[1]);
      end
      n_cmp++;
      if (got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
        n_bad++;
        $display("FAIL trunc_last got %b%b want 01", got_last[0], got_last[1]);
      end
    end
  endtask

  task automatic test_err_and_zero();
    collect(0, 10, 1, 100);
    n_cmp++;
    if (n_err != 1 || got_data.size() != 0 || busy_seen != 0 || n_done != 0) begin
      n_bad++;
      $display("FAIL err_window got err=%0d beats=%0d busy=%0d done=%0d want 1/0/0/0",
               n_err, got_data.size(), busy_seen, n_done);
    end
    n_cmp++;
    if (first_cyc != -1 || timed_out != 0) begin
      n_bad++;
      $display("FAIL err_nobeat got first=%0d timeout=%0d want -1/0", first_cyc, timed_out);
    end
    collect(0, 5, 0, 100);
    n_cmp++;
    if (n_done != 1 || n_err != 0 || got_data.size() != 0) begin
      n_bad++;
      $display("FAIL zero_count got done=%0d err=%0d beats=%0d want 1/0/0", n_done, n_err, got_data.size());
    end
    collect(1, 15, 0, 100);
    n_cmp++;
    if (n_done != 1 || n_err != 0 || got_data.size() != 0) begin
      n_bad++;
      $display("FAIL zero_count_oob got done=%0d err=%0d beats=%0d want 1/0/0", n_done, n_err, got_data.size());
    end
  endtask

  task automatic test_backpressure();
    model_window(0, 0, 10);
    collect(0, 0, 10, 45);
    n_cmp++;
    if (got_data.size() != 10 || timed_out != 0) begin
      n_bad++;
      $display("FAIL bp_size got %0d (timeout=%0d) want 10", got_data.size(), timed_out);
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_cmp++;
        if (got_data[i] !== exp_q[i] || got_last[i] !== (i == 9)) begin
          n_bad++;
          $display("FAIL bp_beat%0d got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_q[i], (i == 9));
        end
      end
    end
    n_cmp++;
    if (n_unstable != 0) begin
      n_bad++;
      $display("FAIL bp_stable got %0d unstable stalls want 0", n_unstable);
    end
  endtask

  task automatic test_concurrent_load();
    int acc_busy, acc;
    model_window(0, 0, 10);
    fork
      collect(0, 0, 10, 100);
      load_probe(0, 4, 500, acc_busy, acc);
    join
    n_cmp++;
    if (acc_busy != 0 || acc != 4) begin
      n_bad++;
      $display("FAIL same_bank_block got busy_accepts=%0d accepted=%0d want 0/4", acc_busy, acc);
    end
    n_cmp++;
    if (got_data.size() != 10 || got_data[9] !== exp_q[9] || got_data[0] !== exp_q[0] || n_done != 1) begin
      n_bad++;
      $display("FAIL same_bank_stream got %0d beats done=%0d want 10/1", got_data.size(), n_done);
    end
    model_window(0, 0, 10);
    fork
      collect(0, 0, 10, 100);
      load_probe(1, 6, 200, acc_busy, acc);
    join
    n_cmp++;
    if (acc_busy == 0 || acc != 6) begin
      n_bad++;
      $display("FAIL other_bank_load got busy_accepts=%0d accepted=%0d want >0/6", acc_busy, acc);
    end
    n_cmp++;
    if (got_data.size() != 4 || exp_q.size() != 4) begin
      n_bad++;
      $display("FAIL reload_size got %0d want 4", got_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (got_data[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL reload_beat%0d got %0d want %0d", i, got_data[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random_windows();
    int b, a, c, p;
    load(0, $urandom_range(1, D), 0, 1'b1);
    load(1, $urandom_range(1, D), 0, 1'b1);
    for (int t = 0; t < 12; t++) begin
      b = $urandom_range(NB - 1);
      a = $urandom_range(D - 1);
      c = $urandom_range(D);
      p = $urandom_range(30, 100);
      model_window(b, a, c);
      collect(b, a, c, p);
      n_cmp++;
      if (timed_out != 0 || n_err != exp_err || n_done != exp_done) begin
        n_bad++;
        $display("FAIL rnd%0d_status got to=%0d err=%0d done=%0d want 0/%0d/%0d (b%0d a%0d c%0d)",
                 t, timed_out, n_err, n_done, exp_err, exp_done, b, a, c);
      end
      n_cmp++;
      if (got_data.size() != exp_q.size() || n_unstable != 0) begin
        n_bad++;
        $display("FAIL rnd%0d_size got %0d beats unstable=%0d want %0d/0", t, got_data.size(),
                 n_unstable, exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_cmp++;
          if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
            n_bad++;
            $display("FAIL rnd%0d_beat%0d got %h/%b want %h/%b", t, i, got_data[i], got_last[i],
                     exp_q[i], (i == exp_q.size() - 1));
          end
        end
      end
    end
  endtask

  task automatic test_fill();
    load(1, D, 300, 1'b0);
    ld_valid = 1'b1;
    ld_data = 16'hdead;
    @(negedge clk);
    n_cmp++;
    if (ld_count !== 5'd16 || ld_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_full got count=%0d ready=%b want 16/0", ld_count, ld_ready);
    end
    step();
    ld_valid = 1'b0;
    model_window(1, 12, 16);
    collect(1, 12, 16, 100);
    n_cmp++;
    if (got_data.size() != 4 || exp_q.size() != 4 || got_data[3] !== 16'd315 || got_last[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_tail got %0d beats want 4 ending 315", got_data.size());
    end
  endtask

  task automatic test_reset_mid_stream();
    rd_start = 1'b1;
    rd_bank = 1'b1;
    rd_addr = '0;
    rd_count = 5'd16;
    rd_ready = 1'b1;
    ld_valid = 1'b1;
    step();
    rd_start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ld_ready, ld_count, rd_valid, rd_data, rd_last, rd_busy, rd_done, rd_err} !== '0) begin
      n_bad++;
      $display("FAIL midrst_outputs got rdy=%b cnt=%0d v=%b d=%h l=%b busy=%b done=%b err=%b want all 0",
               ld_ready, ld_count, rd_valid, rd_data, rd_last, rd_busy, rd_done, rd_err);
    end
    step();
    rst = 1'b0;
    ld_valid = 1'b0;
    for (int b = 0; b < NB; b++) ref_len[b] = 0;
    step();
    model_window(1, 0, 4);
    collect(1, 0, 4, 100);
    n_cmp++;
    if (n_err != exp_err || n_err != 1 || got_data.size() != 0) begin
      n_bad++;
      $display("FAIL midrst_read1 got err=%0d beats=%0d want 1/0", n_err, got_data.size());
    end
    collect(0, 0, 1, 100);
    n_cmp++;
    if (n_err != 1 || got_data.size() != 0) begin
      n_bad++;
      $display("FAIL midrst_read0 got err=%0d beats=%0d want 1/0", n_err, got_data.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_read();
    test_truncate();
    test_err_and_zero();
    test_backpressure();
    test_concurrent_load();
    test_random_windows();
    test_fill();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
